// File: rtl/dsec_ctrl_fsm_if.sv
// DSEC control bus between the DSEC top level and its control FSM.
// Groups the handshake and control signals:
//   controls from the top    : key_config, in_valid, out_rcvd, comp_rdy, scon_done,
//                              valid_bits, flush_req, err_clr
//   controls from the FSM    : stall, rdy, valid_to_comp, out_valid, dump_comp,
//                              error, error_code, err_cnt
// master = side driving the request/status inputs, slave = the FSM.
interface dsec_ctrl_fsm_if #(
    parameter int VB_W      = 7,
    parameter int ERR_CNT_W = 8
);
    logic                 key_config;
    logic                 in_valid;
    logic                 out_rcvd;
    logic                 comp_rdy;
    logic                 scon_done;
    logic [VB_W-1:0]      valid_bits;
    logic                 flush_req;
    logic                 err_clr;

    logic                 stall;
    logic                 rdy;
    logic                 valid_to_comp;
    logic                 out_valid;
    logic                 dump_comp;
    logic                 error;
    logic [3:0]           error_code;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output key_config, in_valid, out_rcvd, comp_rdy, scon_done,
               valid_bits, flush_req, err_clr,
        input  stall, rdy, valid_to_comp, out_valid, dump_comp,
               error, error_code, err_cnt
    );

    modport slave (
        input  key_config, in_valid, out_rcvd, comp_rdy, scon_done,
               valid_bits, flush_req, err_clr,
        output stall, rdy, valid_to_comp, out_valid, dump_comp,
               error, error_code, err_cnt
    );
endinterface

// File: rtl/dsec_ctrl_fsm.sv
// DSEC control FSM. Generates stall / ready / valid / flush controls for the
// compression and shift-concatenation path, holds an output word until the
// receiver acknowledges it, auto-flushes compressor residue after an idle
// period, and watches for a receiver that never acknowledges.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - dsec_ctrl_fsm_if.slave (all control inputs and outputs)
// stall, rdy, valid_to_comp are combinational; out_valid, dump_comp, error,
// error_code, err_cnt are registered.
module dsec_ctrl_fsm #(
    parameter int VB_W        = 7,
    parameter int IDLE_FLUSH  = 16,
    parameter int RCV_TIMEOUT = 255,
    parameter int ERR_CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    dsec_ctrl_fsm_if.slave bus
);
    typedef enum logic [2:0] {S_CFG, S_RUN, S_HOLD, S_FLUSH, S_ERR} state_t;

    localparam int IDL_W    = (IDLE_FLUSH  > 0) ? $clog2(IDLE_FLUSH + 1)  : 1;
    localparam int TMO_W    = (RCV_TIMEOUT > 0) ? $clog2(RCV_TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (RCV_TIMEOUT > 0) ? RCV_TIMEOUT - 1 : 0;

    state_t               state;
    logic [IDL_W-1:0]     idle_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 flush_empty;   // FLUSH was entered with no residue
    logic                 out_valid_q;
    logic                 dump_q;
    logic                 err_q;
    logic [3:0]           code_q;
    logic [ERR_CNT_W-1:0] cnt_q;

    logic       stall_c, rdy_c, vb_nz, idle_hit, tmo_hit;
    logic       ev1, ev2, ev3, ev4, any_ev;
    logic [3:0] ev_code;

    always_comb begin
        stall_c  = bus.key_config | (state == S_CFG) | (state == S_ERR)
                 | ((state == S_HOLD) & ~bus.out_rcvd);
        rdy_c    = bus.comp_rdy & ((state == S_RUN) | (state == S_HOLD)) & ~stall_c;
        vb_nz    = |bus.valid_bits;
        idle_hit = (IDLE_FLUSH != 0) && (idle_cnt == IDL_W'(IDLE_FLUSH));
        // Fires on the RCV_TIMEOUT-th consecutive unacknowledged HOLD cycle.
        tmo_hit  = (RCV_TIMEOUT != 0) && (tmo_cnt == TMO_W'(TMO_LAST));

        ev1 = bus.in_valid & ~rdy_c & (state != S_CFG);
        ev2 = (state == S_HOLD) & bus.scon_done & ~bus.out_rcvd;
        ev3 = (state == S_HOLD) & ~bus.out_rcvd & tmo_hit;
        ev4 = (state == S_FLUSH) & bus.flush_req;
        any_ev = ev1 | ev2 | ev3 | ev4;
        // Lowest code wins when several events coincide.
        if (ev1)      ev_code = 4'd1;
        else if (ev2) ev_code = 4'd2;
        else if (ev3) ev_code = 4'd3;
        else if (ev4) ev_code = 4'd4;
        else          ev_code = 4'd0;
    end

    assign bus.stall         = stall_c;
    assign bus.rdy           = rdy_c;
    assign bus.valid_to_comp = bus.in_valid & rdy_c;
    assign bus.out_valid     = out_valid_q;
    assign bus.dump_comp     = dump_q;
    assign bus.error         = err_q;
    assign bus.error_code    = code_q;
    assign bus.err_cnt       = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_CFG;
            idle_cnt    <= '0;
            tmo_cnt     <= '0;
            flush_empty <= 1'b0;
            out_valid_q <= 1'b0;
            dump_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
            cnt_q       <= '0;
        end else begin
            // Sticky error capture; a clear in the same cycle as a new event
            // keeps the new event as the first error.
            if (bus.err_clr) begin
                err_q  <= any_ev;
                code_q <= ev_code;
                cnt_q  <= ERR_CNT_W'(any_ev);
            end else if (any_ev) begin
                if (!err_q) begin
                    err_q  <= 1'b1;
                    code_q <= ev_code;
                end
                if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
            end

            if ((state == S_RUN) && !bus.in_valid && vb_nz) begin
                if (idle_cnt != IDL_W'(IDLE_FLUSH)) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            if ((state == S_HOLD) && !bus.out_rcvd) begin
                if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            dump_q      <= 1'b0;
            out_valid_q <= 1'b0;

            if (state == S_ERR) begin
                if (bus.err_clr) state <= S_CFG;
            end else if (ev2 | ev3) begin
                state <= S_ERR;
            end else if (bus.key_config) begin
                state <= S_CFG;
            end else begin
                case (state)
                    S_CFG: state <= S_RUN;
                    S_RUN: begin
                        if (bus.scon_done) begin
                            state       <= S_HOLD;
                            out_valid_q <= 1'b1;
                        end else if (bus.flush_req | idle_hit) begin
                            // Residue is sampled as FLUSH is entered, so the
                            // dump pulse lines up with the first FLUSH cycle.
                            state       <= S_FLUSH;
                            dump_q      <= vb_nz;
                            flush_empty <= ~vb_nz;
                        end
                    end
                    S_HOLD: begin
                        // Acknowledge with a new word ready keeps HOLD, no bubble.
                        if (bus.out_rcvd && !bus.scon_done) state <= S_RUN;
                        else out_valid_q <= 1'b1;
                    end
                    S_FLUSH: begin
                        if (flush_empty) begin
                            state <= S_RUN;
                        end else if (bus.scon_done) begin
                            state       <= S_HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: state <= S_CFG;
                endcase
            end
        end
    end
endmodule

// File: doc/dsec_ctrl_fsm.md
Name: dsec_ctrl_fsm

Overview:
Parametrised control FSM for the data stream compression/encryption (DSEC) top level. It generates stall, ready, valid and flush controls for the compression and shift-concatenation path. Output data is held until the receiver acknowledges it. Errors are captured sticky with a first-error code and a saturating error counter. An idle timer auto-flushes partial compressor data, and a watchdog detects a receiver that never acknowledges.

Parameters:
VB_W, 7, width of valid_bits (compressor residue bit count)
IDLE_FLUSH, 16, consecutive idle RUN cycles before auto dump; 0 disables auto dump
RCV_TIMEOUT, 255, max HOLD cycles awaiting out_rcvd before timeout error; 0 disables
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
key_config  in  1  encryption key configuration in progress
in_valid  in  1  valid input word on DSEC input bus
out_rcvd  in  1  receiver accepted current output word
comp_rdy  in  1  compression module can accept input
scon_done  in  1  shift-concat has a full 64-bit word
valid_bits  in  VB_W  residual valid bits held in compressor
flush_req  in  1  external request to dump compressor residue
err_clr  in  1  clears error, error_code, err_cnt
stall  out  1  all datapath modules hold state
rdy  out  1  DSEC ready for input
valid_to_comp  out  1  qualified input valid to compressor
out_valid  out  1  DSEC output word valid
dump_comp  out  1  one-cycle pulse: compressor emits residue
error  out  1  sticky error flag
error_code  out  4  first error code since last clear
err_cnt  out  ERR_CNT_W  saturating count of error events

Behaviour:
- Reset values: state CFG, all outputs 0, idle and timeout counters 0.
- States: CFG, RUN, HOLD, FLUSH, ERR. All transitions are registered on posedge clk.
- CFG: stall=1. Exit to RUN on the first cycle key_config=0. key_config=1 in any state except ERR forces CFG next cycle and clears out_valid.
- RUN: scon_done=1 -> HOLD, with out_valid=1 from the next cycle. flush_req=1, or the idle counter reaching IDLE_FLUSH, -> FLUSH.
- HOLD: out_valid stays 1; stall = ~out_rcvd.
  - out_rcvd=1 -> out_valid=0 next cycle and return to RUN. If scon_done=1 in that same cycle, stay in HOLD with out_valid held at 1 (back-to-back word, no bubble).
- FLUSH: dump_comp pulses exactly 1 cycle on entry.
  - If valid_bits==0 on the entry cycle, no pulse is issued and the state returns to RUN.
  - Otherwise the FSM waits for scon_done, then goes to HOLD.
- ERR: stall=1, rdy=0. Exit to CFG on err_clr=1.
- Combinational outputs:
  - rdy = comp_rdy & state∈{RUN,HOLD} & ~stall.
  - valid_to_comp = in_valid & rdy.
  - stall = key_config | state∈{CFG,ERR} | (state==HOLD & ~out_rcvd).
- Idle counter: increments each RUN cycle with in_valid=0 and valid_bits≠0. Resets on in_valid=1, on leaving RUN, or on valid_bits==0. Saturates at IDLE_FLUSH.
- Timeout counter: counts HOLD cycles and resets on out_rcvd. Reaching RCV_TIMEOUT raises error code 3.
- Error codes:
  - 1: in_valid=1 while rdy=0, outside CFG.
  - 2: scon_done=1 in HOLD with out_rcvd=0 (overrun).
  - 3: receiver timeout.
  - 4: flush_req=1 while in FLUSH.
- Error handling:
  - Code 2 or 3 moves the FSM to ERR. Codes 1 and 4 only set the flags and the state continues.
  - error and error_code update only when error=0 (first-error capture). Simultaneous errors: the lowest code wins.
  - err_cnt increments once per cycle that has any error event and saturates at all-ones.
- err_clr=1 clears error, error_code and err_cnt next cycle. If an error event occurs in the same cycle, the new event is captured and err_cnt becomes 1.
- Latency: scon_done -> out_valid is 1 cycle. out_rcvd -> out_valid low is 1 cycle.
- Mid-operation reset clears everything immediately (asynchronously). No output pulse survives reset.

Test Plan:
- Reset, key_config=1 for 3 cycles then 0, comp_rdy=1 -> stall=1 through CFG; RUN on cycle 4; rdy=1, stall=0.
- In RUN, pulse scon_done; out_rcvd low 5 cycles then high -> out_valid=1 for cycles 1..6; stall=1 cycles 1..5; out_valid=0 at cycle 7.
- scon_done every cycle with out_rcvd=1 every cycle -> out_valid continuously 1; no error; err_cnt=0.
- valid_bits=13, in_valid=0, IDLE_FLUSH=16 -> single dump_comp pulse after 16 idle cycles; scon_done then gives out_valid. Repeat with valid_bits=0 -> no pulse.
- In HOLD, scon_done=1 with out_rcvd=0 and in_valid=1, rdy=0 in the same cycle -> error=1, error_code=1 (lowest), err_cnt=1, state ERR, stall=1. err_clr -> all cleared, CFG.
- Hold out_rcvd=0 for 255 cycles (RCV_TIMEOUT=255) -> error_code=3, ERR. Generate 300 code-1 events -> err_cnt saturates at 255.
